// File: rtl/fp_pkg.sv
// Shared fp32 field layout and accumulator state encoding.
// Used by fp_accum_seq and FloatingPointAdder.
package fp_pkg;

    localparam int SIGN_BIT = 31;
    localparam int EXP_MSB  = 30;
    localparam int EXP_LSB  = 23;
    localparam int MAN_MSB  = 22;
    localparam int EXP_W    = 8;
    localparam int MAN_W    = 23;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/fp_accum_seq_adder.sv
// Combinational fp32 magnitude adder (no subtraction, truncating).
// Zero/denormal inputs are flushed to zero; the larger operand's sign is kept.
module FloatingPointAdder
    import fp_pkg::*;
(
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] Out
);

    logic [EXP_W-1:0] ea, eb, eh, el, d, eo;
    logic [MAN_W:0]   ma, mb, mh, ml, mls;
    logic [MAN_W+1:0] s;
    logic [MAN_W-1:0] mo;
    logic             sh;

    // Align the smaller operand, add significands, renormalise once.
    always_comb begin
        ea  = A[EXP_MSB:EXP_LSB];
        eb  = B[EXP_MSB:EXP_LSB];
        ma  = (ea == '0) ? '0 : {1'b1, A[MAN_MSB:0]};
        mb  = (eb == '0) ? '0 : {1'b1, B[MAN_MSB:0]};
        if (ea >= eb) begin
            eh = ea;
            el = eb;
            mh = ma;
            ml = mb;
            sh = A[SIGN_BIT];
        end else begin
            eh = eb;
            el = ea;
            mh = mb;
            ml = ma;
            sh = B[SIGN_BIT];
        end
        d   = eh - el;
        mls = (d > 8'd23) ? '0 : (ml >> d);
        s   = {1'b0, mh} + {1'b0, mls};
        if (s[MAN_W+1]) begin
            eo = eh + 8'd1;
            mo = s[MAN_W:1];
        end else begin
            eo = eh;
            mo = s[MAN_W-1:0];
        end
        if (eh == '0) begin
            Out = 32'h0000_0000;
        end else if (eh == 8'hFF || eo == 8'hFF) begin
            Out = {sh, 8'hFF, 23'd0};
        end else begin
            Out = {sh, eo, mo};
        end
    end

endmodule

// File: rtl/fp_accum_seq.sv
// Packet accumulator feeding FloatingPointAdder; one operand per cycle.
// Optional macro FP_ACC_NEG_REJECT_EN drops negative operands and pulses err.
module fp_accum_seq
    import fp_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [CNT_W-1:0] out_count,
    output logic             err
);

    state_t             state;
    logic [31:0]        acc;
    logic [CNT_W-1:0]   cnt;
    logic [31:0]        sum;
    logic               fire_in;
    logic               fire_out;
    logic               drop;
    logic [CNT_W-1:0]   cnt_inc;

    FloatingPointAdder u_add (
        .A   (acc),
        .B   (in_data),
        .Out (sum)
    );

    assign in_ready  = (state != HOLD);
    assign out_valid = (state == HOLD);
    assign fire_in   = in_valid & in_ready;
    assign fire_out  = out_valid & out_ready;
    assign out_data  = acc;
    assign out_count = cnt;
    assign cnt_inc   = (cnt == '1) ? cnt : cnt + 1'b1;

`ifdef FP_ACC_NEG_REJECT_EN
    logic err_q;

    assign drop = in_data[SIGN_BIT];
    assign err  = err_q;

    // One-cycle pulse for each accepted negative operand.
    always_ff @(posedge clk) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= fire_in & drop;
    end
`else
    assign drop = 1'b0;
    assign err  = 1'b0;
`endif

    // Packet FSM with running sum and saturating element count.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (fire_in) begin
                        if (drop) begin
                            acc <= '0;
                            cnt <= '0;
                        end else begin
                            acc <= in_data;
                            cnt <= {{(CNT_W-1){1'b0}}, 1'b1};
                        end
                        state <= in_last ? HOLD : ACC;
                    end
                end
                ACC: begin
                    if (fire_in) begin
                        if (!drop) begin
                            acc <= sum;
                            cnt <= cnt_inc;
                        end
                        if (in_last) state <= HOLD;
                    end
                end
                HOLD: begin
                    if (fire_out) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/fp_accum_seq.md
# fp_accum_seq

Sequential accumulator for IEEE-754 single-precision operands. It sits directly upstream of the combinational `FloatingPointAdder`: it accepts a packet of operands over a valid/ready stream, feeds the running sum and each new operand into the adder, and registers the adder output once per cycle. When the last operand arrives it presents the packet total and element count on a valid/ready output port.

## Interface
- `CNT_W`, default 16: width of the element counter and of `out_count`.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous reset, active-high.
- `in_valid`  in  1  operand beat valid.
- `in_ready`  out  1  block accepts a beat this cycle.
- `in_data`  in  32  fp32 operand.
- `in_last`  in  1  beat is the final element of the packet.
- `out_valid`  out  1  packet result valid.
- `out_ready`  in  1  downstream accepts the result.
- `out_data`  out  32  fp32 packet sum.
- `out_count`  out  CNT_W  number of operands accumulated, saturating.
- `err`  out  1  one-cycle pulse flagging a rejected operand (only when the macro is enabled).

## Operation
- Input fire = `in_valid & in_ready`; output fire = `out_valid & out_ready`.
- States:
  - IDLE: `in_ready`=1; no packet open; `acc` is don't-care.
  - ACC: `in_ready`=1; packet open.
  - HOLD: `in_ready`=0; `out_valid`=1.
- First accepted beat of a packet (in IDLE): `acc <= in_data` loaded directly, not through the adder; `cnt <= 1`.
- Later accepted beats (in ACC): `acc <= adder(acc, in_data)`; `cnt <= cnt+1`, saturating at all-ones.
- Transitions:
  - IDLE→ACC on a fire with `in_last`=0.
  - IDLE→HOLD on a fire with `in_last`=1, giving a single-element packet.
  - ACC→HOLD on a fire with `in_last`=1.
  - HOLD→IDLE on output fire.
- `out_data` = `acc` and `out_count` = `cnt`. Both are held stable for the whole of HOLD.
- Adder operands: `add_a` = `acc`, `add_b` = `in_data`. The adder's internal rounding and normalisation are taken as-is; no post-processing.
- Reset values: state = IDLE, `acc` = 0, `cnt` = 0, `out_valid` = 0, `err` = 0. `in_ready` = 1 from the first cycle after reset.
- Reset mid-packet or during HOLD discards the partial sum and any pending result.

## Timing
- Throughput: one operand per cycle while in IDLE or ACC.
- Latency: the result is visible (`out_valid`=1) the cycle after the `in_last` beat fires.
- While in HOLD, `in_ready`=0 even in the cycle of output fire. The next packet's first beat is accepted no earlier than the cycle after the output fire.
- `out_valid` never drops without an output fire, except on `rst`.
- The adder sits in a single combinational path, from the `acc` register through the adder to the `acc` D input. No internal pipelining.

## Configuration
- Macro `FP_ACC_NEG_REJECT_EN`. It exists because the adder does not implement subtraction.
- Defined:
  - An accepted beat with `in_data[31]`=1 is dropped: `acc` and `cnt` are unchanged, and `err` pulses high for one cycle.
  - If the dropped beat carries `in_last`, the packet still closes.
  - A packet with zero surviving elements reports `out_data`=0x00000000 and `out_count`=0.
- Undefined: negative operands pass to the adder unchanged, and `err` is tied 0.

## Structure
- Shared package `fp_pkg`: the fp32 field widths and positions (sign bit 31, exponent [30:23], mantissa [22:0]) and the state enum {IDLE, ACC, HOLD}.
- One sub-module: an instance of the existing `FloatingPointAdder` (ports A, B, Out). No other hierarchy.

## Test plan
- Packet 0x3F800000, 0x40000000, 0x40400000 (1, 2, 3), last on the third beat → `out_data`=0x40C00000 (6.0), `out_count`=3, `out_valid` asserted one cycle after the last beat.
- Single beat 0x3F000000 (0.5) with `in_last`=1 → `out_data`=0x3F000000, `out_count`=1, HOLD entered directly from IDLE.
- Hold `out_ready`=0 for 3 cycles with `in_valid`=1 → `in_ready`=0 and `out_data`/`out_count` stable throughout. Release → the next packet's first beat is accepted the cycle after output fire.
- With the macro defined: packet 0x40000000, 0xBF800000, 0x40000000 (last) → `err` pulses on beat 2, `out_data`=0x40800000 (4.0), `out_count`=2. The same stimulus without the macro yields `err`=0 and `out_count`=3.
- Assert `rst` after 2 of 4 beats → `out_valid`=0 and `in_ready`=1 the next cycle. A fresh packet 1.0, 1.0 (last) → 0x40000000, count 2.
- Run 70000 beats of 0x00000000 with `CNT_W`=16 → `out_count` saturates at 0xFFFF, `out_data`=0x00000000.
